mem_arbiter: RTL and testbench

//  Shares the single SPI mem_controller between the CPU instruction-fetch port (P0) and
//  the load/store data port (P1). Grants one requester at a time and registers the

---
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SPI mem_controller between the fetch port (P0) and the data port (P1),
// holding the grant through a full done/req release handshake, with an optional hang watchdog.
module mem_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    output logic        p0_done,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [2:0]  p1_num_bytes,
    input  logic        p1_write,
    input  logic [31:0] p1_wdata,
    output logic        p1_done,
    output logic [31:0] p1_rdata,
    output logic        mem_start,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_num_bytes,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic        mem_is_data,
    input  logic        mem_done,
    input  logic [31:0] mem_instr_rd,
    input  logic [31:0] mem_data_rd,
    output logic [1:0]  grant,
    output logic        timeout_err
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    logic [1:0]  state;
    logic        rr_ptr;
    logic [15:0] cnt;
    logic        tie;
    logic        pick_p1;
    logic        own_req;
    logic        expire;
    always_comb begin
        tie     = p0_req & p1_req;
        pick_p1 = p1_req & (~p0_req | (ARB_MODE == 0) | rr_ptr);
        own_req = grant[1] ? p1_req : p0_req;
        expire  = (TIMEOUT > 0) && (({1'b0, cnt} + 17'd1) == 17'(TIMEOUT));
    end
    // rr_ptr names the port that wins the next tie; it only moves on a tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            cnt           <= '0;
            grant         <= '0;
            mem_start     <= 1'b0;
            mem_addr      <= '0;
            mem_num_bytes <= '0;
            mem_write     <= 1'b0;
            mem_wdata     <= '0;
            mem_is_data   <= 1'b0;
            p0_done       <= 1'b0;
            p0_rdata      <= '0;
            p1_done       <= 1'b0;
            p1_rdata      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!mem_done && (p0_req || p1_req)) begin
                    state         <= GRANT;
                    grant         <= pick_p1 ? 2'b10 : 2'b01;
                    mem_start     <= 1'b1;
                    cnt           <= '0;
                    mem_addr      <= pick_p1 ? p1_addr : p0_addr;
                    mem_num_bytes <= pick_p1 ? p1_num_bytes : 3'd4;
                    mem_write     <= pick_p1 & p1_write;
                    mem_wdata     <= pick_p1 ? p1_wdata : '0;
                    mem_is_data   <= pick_p1 & ~p1_write;
                    if (tie) rr_ptr <= ~pick_p1;
                end
                GRANT: if (mem_done || expire) begin
                    state     <= RELEASE;
                    mem_start <= 1'b0;
                    p0_done   <= grant[0];
                    p1_done   <= grant[1];
                    if (grant[0]) p0_rdata <= mem_done ? mem_instr_rd : '0;
                    if (grant[1]) p1_rdata <= (mem_done && !mem_write) ? mem_data_rd : '0;
                    if (!mem_done) timeout_err <= 1'b1;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                RELEASE: if (!own_req && !mem_done) begin
                    state   <= IDLE;
                    grant   <= '0;
                    p0_done <= 1'b0;
                    p1_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (fixed priority + 100-cycle watchdog, round-robin without watchdog)
// driven by directed scenarios and random requesters, checked every cycle against a transaction model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n;
    logic        p0_req [2];
    logic        p1_req [2];
    logic        p1_write [2];
    logic        mem_done [2];
    logic [31:0] p0_addr [2];
    logic [31:0] p1_addr [2];
    logic [31:0] p1_wdata [2];
    logic [31:0] mem_instr_rd [2];
    logic [31:0] mem_data_rd [2];
    logic [2:0]  p1_num_bytes [2];
    wire         p0_done [2];
    wire         p1_done [2];
    wire         mem_start [2];
    wire         mem_write [2];
    wire         mem_is_data [2];
    wire         timeout_err [2];
    wire  [31:0] p0_rdata [2];
    wire  [31:0] p1_rdata [2];
    wire  [31:0] mem_addr [2];
    wire  [31:0] mem_wdata [2];
    wire  [2:0]  mem_num_bytes [2];
    wire  [1:0]  grant [2];

    for (genvar g = 0; g < 2; g++) begin : gd
        mem_arbiter #(.ARB_MODE(g), .TIMEOUT(g == 0 ? 100 : 0)) dut (
            .clk(clk), .rst_n(rst_n),
            .p0_req(p0_req[g]), .p0_addr(p0_addr[g]), .p0_done(p0_done[g]), .p0_rdata(p0_rdata[g]),
            .p1_req(p1_req[g]), .p1_addr(p1_addr[g]), .p1_num_bytes(p1_num_bytes[g]),
            .p1_write(p1_write[g]), .p1_wdata(p1_wdata[g]), .p1_done(p1_done[g]), .p1_rdata(p1_rdata[g]),
            .mem_start(mem_start[g]), .mem_addr(mem_addr[g]), .mem_num_bytes(mem_num_bytes[g]),
            .mem_write(mem_write[g]), .mem_wdata(mem_wdata[g]), .mem_is_data(mem_is_data[g]),
            .mem_done(mem_done[g]), .mem_instr_rd(mem_instr_rd[g]), .mem_data_rd(mem_data_rd[g]),
            .grant(grant[g]), .timeout_err(timeout_err[g])
        );
    end

    int checks = 0;
    int failures = 0;
    bit chk_on = 0;
    bit rand_mode = 0;
    int auto_req = 0;
    int lat [2];
    bit hang [2];
    int ccnt [2];

    // transaction-level reference: who owns the controller, and has its result been delivered
    int          owner [2];
    bit          fin [2];
    int          busy [2];
    int          tie_pref [2];
    logic [31:0] m_addr [2], m_wd [2], m_rd0 [2], m_rd1 [2];
    logic [2:0]  m_nb [2];
    bit          m_wr [2], m_isd [2], m_terr [2];

    function automatic int timeout_of(int d);
        return d == 0 ? 100 : 0;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                owner[d] = -1; fin[d] = 0; busy[d] = 0; tie_pref[d] = 0;
                m_addr[d] = 0; m_nb[d] = 0; m_wr[d] = 0; m_wd[d] = 0; m_isd[d] = 0;
                m_rd0[d] = 0; m_rd1[d] = 0; m_terr[d] = 0;
            end else if (owner[d] < 0) begin
                if (!mem_done[d] && (p0_req[d] || p1_req[d])) begin
                    owner[d] = (p0_req[d] && p1_req[d]) ? (d == 0 ? 1 : tie_pref[d]) : (p1_req[d] ? 1 : 0);
                    if (p0_req[d] && p1_req[d]) tie_pref[d] = 1 - owner[d];
                    fin[d] = 0;
                    busy[d] = 0;
                    if (owner[d] == 1) begin
                        m_addr[d] = p1_addr[d]; m_nb[d] = p1_num_bytes[d]; m_wr[d] = p1_write[d];
                        m_wd[d] = p1_wdata[d]; m_isd[d] = !p1_write[d];
                    end else begin
                        m_addr[d] = p0_addr[d]; m_nb[d] = 4; m_wr[d] = 0; m_wd[d] = 0; m_isd[d] = 0;
                    end
                end
            end else if (!fin[d]) begin
                busy[d]++;
                if (mem_done[d]) begin
                    fin[d] = 1;
                    if (owner[d] == 0) m_rd0[d] = mem_instr_rd[d];
                    else m_rd1[d] = m_wr[d] ? 32'd0 : mem_data_rd[d];
                end else if (timeout_of(d) > 0 && busy[d] == timeout_of(d)) begin
                    fin[d] = 1;
                    m_terr[d] = 1;
                    if (owner[d] == 0) m_rd0[d] = 0;
                    else m_rd1[d] = 0;
                end
            end else if (!(owner[d] == 0 ? p0_req[d] : p1_req[d]) && !mem_done[d]) begin
                owner[d] = -1;
                fin[d] = 0;
            end
        end
    end

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h expected=%h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // one cycle: compare against the model, then advance the controller and requester stimulus
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (chk_on) begin
                chk("grant", d, grant[d], owner[d] < 0 ? 0 : (owner[d] == 0 ? 1 : 2));
                chk("mem_start", d, mem_start[d], owner[d] >= 0 && !fin[d]);
                chk("mem_addr", d, mem_addr[d], m_addr[d]);
                chk("mem_num_bytes", d, mem_num_bytes[d], m_nb[d]);
                chk("mem_write", d, mem_write[d], m_wr[d]);
                chk("mem_wdata", d, mem_wdata[d], m_wd[d]);
                chk("mem_is_data", d, mem_is_data[d], m_isd[d]);
                chk("p0_done", d, p0_done[d], owner[d] == 0 && fin[d]);
                chk("p1_done", d, p1_done[d], owner[d] == 1 && fin[d]);
                chk("p0_rdata", d, p0_rdata[d], m_rd0[d]);
                chk("p1_rdata", d, p1_rdata[d], m_rd1[d]);
                chk("timeout_err", d, timeout_err[d], m_terr[d]);
            end
            if (!rst_n) begin
                ccnt[d] = 0;
                mem_done[d] = 0;
            end else if (mem_start[d]) begin
                if (ccnt[d] == 0 && rand_mode) begin
                    lat[d] = $urandom_range(1, 6);
                    hang[d] = (d == 0) && ($urandom_range(0, 19) == 0);
                end
                ccnt[d]++;
                mem_done[d] = !hang[d] && ccnt[d] >= lat[d];
            end else begin
                ccnt[d] = 0;
                mem_done[d] = 0;
            end
            if (rand_mode) begin
                mem_instr_rd[d] = $urandom;
                mem_data_rd[d] = $urandom;
            end
            if (auto_req > 0) begin
                if (p0_req[d] && p0_done[d]) begin
                    if ($urandom_range(0, 1) == 1) p0_req[d] = 0;
                end else if (!p0_req[d] && auto_req == 2 && $urandom_range(0, 3) == 0) begin
                    p0_addr[d] = $urandom;
                    p0_req[d] = 1;
                end
                if (p1_req[d] && p1_done[d]) begin
                    if ($urandom_range(0, 1) == 1) p1_req[d] = 0;
                end else if (!p1_req[d] && auto_req == 2 && $urandom_range(0, 3) == 0) begin
                    p1_addr[d] = $urandom;
                    p1_wdata[d] = $urandom;
                    p1_write[d] = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 2))
                        0: p1_num_bytes[d] = 3'd1;
                        1: p1_num_bytes[d] = 3'd2;
                        default: p1_num_bytes[d] = 3'd4;
                    endcase
                    p1_req[d] = 1;
                end
            end
        end
    endtask

    initial begin
        int n, cnt;
        logic [1:0] first [2];
        rst_n = 0;
        for (int d = 0; d < 2; d++) begin
            p0_req[d] = 0; p1_req[d] = 0; p1_write[d] = 0; mem_done[d] = 0;
            p0_addr[d] = 0; p1_addr[d] = 0; p1_wdata[d] = 0; p1_num_bytes[d] = 4;
            mem_instr_rd[d] = 0; mem_data_rd[d] = 0; lat[d] = 2; hang[d] = 0; ccnt[d] = 0;
        end
        tick();
        chk_on = 1;
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_grant", d, grant[d], 0);
            chk("rst_start", d, mem_start[d], 0);
            chk("rst_terr", d, timeout_err[d], 0);
        end
        rst_n = 1;
        tick();
        // fetch only, slow controller
        for (int d = 0; d < 2; d++) begin
            lat[d] = 40; mem_instr_rd[d] = 32'h0050_0093; p0_addr[d] = 32'h10; p0_req[d] = 1;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("t1_start", d, mem_start[d], 1);
            chk("t1_nb", d, mem_num_bytes[d], 4);
            chk("t1_addr", d, mem_addr[d], 32'h10);
            chk("t1_grant", d, grant[d], 1);
        end
        n = 0;
        while (!p0_done[0] && n < 100) begin tick(); n++; end
        chk("t1_done_seen", 0, p0_done[0], 1);
        for (int d = 0; d < 2; d++) chk("t1_rdata", d, p0_rdata[d], 32'h0050_0093);
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin chk("t1_done_held", d, p0_done[d], 1); p0_req[d] = 0; end
        tick();
        for (int d = 0; d < 2; d++) begin chk("t1_done_off", d, p0_done[d], 0); chk("t1_idle", d, grant[d], 0); end
        // data store
        for (int d = 0; d < 2; d++) begin
            lat[d] = 3; mem_data_rd[d] = 32'hDEAD_BEEF; p1_addr[d] = 32'h2000; p1_num_bytes[d] = 2;
            p1_write[d] = 1; p1_wdata[d] = 32'hBEEF_0000; p1_req[d] = 1;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("t2_write", d, mem_write[d], 1);
            chk("t2_is_data", d, mem_is_data[d], 0);
            chk("t2_wdata", d, mem_wdata[d], 32'hBEEF_0000);
            chk("t2_nb", d, mem_num_bytes[d], 2);
            chk("t2_grant", d, grant[d], 2);
        end
        n = 0;
        while (!(p1_done[0] && p1_done[1]) && n < 50) begin tick(); n++; end
        for (int d = 0; d < 2; d++) begin
            chk("t2_done_seen", d, p1_done[d], 1);
            chk("t2_rdata", d, p1_rdata[d], 0);
            p1_req[d] = 0;
        end
        tick();
        for (int d = 0; d < 2; d++) begin p1_write[d] = 0; p1_num_bytes[d] = 4; lat[d] = 2; end
        // simultaneous requests, three rounds
        auto_req = 1;
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 2; d++) begin
                p0_addr[d] = 32'h100 + r; p1_addr[d] = 32'h200 + r; p0_req[d] = 1; p1_req[d] = 1; first[d] = 0;
            end
            n = 0;
            do begin
                tick();
                for (int d = 0; d < 2; d++) if (first[d] == 0) first[d] = grant[d];
                n++;
            end while ((p0_req[0] || p1_req[0] || p0_req[1] || p1_req[1] || grant[0] != 0 || grant[1] != 0) && n < 200);
            chk("t3_fixed_first", 0, first[0], 2);
            chk("t3_rr_first", 1, first[1], (r % 2 == 0) ? 2'd1 : 2'd2);
        end
        // data request arriving while a fetch is in flight
        for (int d = 0; d < 2; d++) begin lat[d] = 10; p0_addr[d] = 32'h40; p0_req[d] = 1; end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin p1_addr[d] = 32'h3000; p1_req[d] = 1; end
        tick();
        for (int d = 0; d < 2; d++) begin chk("t4_hold_addr", d, mem_addr[d], 32'h40); chk("t4_hold_grant", d, grant[d], 1); end
        n = 0;
        while (!(grant[0] == 2 && grant[1] == 2) && n < 100) begin tick(); n++; end
        for (int d = 0; d < 2; d++) begin chk("t4_p1_grant", d, grant[d], 2); chk("t4_p1_addr", d, mem_addr[d], 32'h3000); end
        n = 0;
        while ((p0_req[0] || p1_req[0] || p0_req[1] || p1_req[1] || grant[0] != 0 || grant[1] != 0) && n < 100) begin tick(); n++; end
        // hung controller on the watchdog instance
        auto_req = 0;
        hang[0] = 1; lat[1] = 5;
        for (int d = 0; d < 2; d++) begin p0_addr[d] = 32'h80; p0_req[d] = 1; end
        cnt = 0; n = 0;
        while (!p0_done[0] && n < 300) begin tick(); if (mem_start[0]) cnt++; n++; end
        chk("t5_start_cycles", 0, cnt, 100);
        chk("t5_start_low", 0, mem_start[0], 0);
        chk("t5_done", 0, p0_done[0], 1);
        chk("t5_terr", 0, timeout_err[0], 1);
        chk("t5_rdata", 0, p0_rdata[0], 0);
        chk("t5_no_wdog", 1, timeout_err[1], 0);
        for (int d = 0; d < 2; d++) p0_req[d] = 0;
        repeat (2) tick();
        chk("t5_terr_sticky", 0, timeout_err[0], 1);
        chk("t5_released", 0, grant[0], 0);
        hang[0] = 0;
        // reset in the middle of a grant
        for (int d = 0; d < 2; d++) begin lat[d] = 20; p1_addr[d] = 32'h5000; p1_req[d] = 1; end
        repeat (5) tick();
        rst_n = 0;
        for (int d = 0; d < 2; d++) p1_req[d] = 0;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("t6_grant", d, grant[d], 0);
            chk("t6_start", d, mem_start[d], 0);
            chk("t6_addr", d, mem_addr[d], 0);
            chk("t6_terr", d, timeout_err[d], 0);
        end
        rst_n = 1;
        tick();
        // random traffic
        rand_mode = 1;
        auto_req = 2;
        repeat (4000) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
